opcode_dispatch: RTL and testbench

- Upstream feeder for the accumulator/ALU stage, which consumes a 3-bit casez opcode, a 16-bit data_bus, a bloc_xfer loop flag and a RAM address.
- Buffers incoming commands in a small FIFO and issues them one at a time.
- Single commands are issued with a valid/ready handshake.
- Block-transfer commands (opcode 000) are expanded into len words, 5 clock cycles per word, matching the ALU's repeat(5) loop.

---
 rtl/opcode_dispatch.sv | 169 ++++++++++++++++
 tb/tb_opcode_dispatch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_dispatch.sv
// opcode_dispatch: command FIFO feeding the accumulator/ALU stage.
// Single commands go out on a valid/ready handshake. Block-transfer
// commands (opcode 000) expand into len words of 5 cycles each and
// step the RAM address pointer once per word.
// Optional build macro: DISPATCH_BYTE_SWAP_EN -- byte-swaps data_bus for
// opcode 011 while it is being issued.
module opcode_dispatch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [15:0]              in_data,
  input  logic [7:0]               in_len,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [2:0]               opcode,
  output logic [15:0]              data_bus,
  output logic                     bloc_xfer,
  output logic [ADDR_W-1:0]        address,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BLOCK} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] data;
    logic [7:0]  len;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_d;
  logic [15:0]      data_q;
  logic [7:0]       len_q;
  logic [2:0]       beat;
  logic [7:0]       word;
  logic             beat_last;
  logic             word_last;

  // A full FIFO refuses input even if the head is popped in the same cycle.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign beat_last = (beat == 3'd4);
  assign word_last = (word == len_q - 8'd1);

  // FIFO storage: written on push only.
  // NOTE: the storage array has no reset; level and the pointers define
  // which entries are meaningful, so resetting the data buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_data, in_len};
  end

  // FIFO pointers and fill count.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode, pop request and ALU-facing outputs.
  // NOTE: every signal gets a default before the case statement so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    op_valid  = 1'b0;
    bloc_xfer = 1'b0;
    data_bus  = data_q;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop = 1'b1;
          if (head.op != 3'b000)     state_d = ISSUE;
          else if (head.len != 8'd0) state_d = BLOCK;
        end
      end
      ISSUE: begin
        op_valid = 1'b1;
`ifdef DISPATCH_BYTE_SWAP_EN
        if (opcode == 3'b011) data_bus = {data_q[7:0], data_q[15:8]};
`endif
        if (op_ready) state_d = IDLE;
      end
      BLOCK: begin
        bloc_xfer = 1'b1;
        data_bus  = data_q + {8'h00, word};
        if (beat_last && word_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, block counters, address pointer and retire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      beat    <= '0;
      word    <= '0;
      address <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            opcode <= head.op;
            data_q <= head.data;
            len_q  <= head.len;
            beat   <= '0;
            word   <= '0;
            // A zero-length block retires immediately as a NOP.
            if (head.op == 3'b000 && head.len == 8'd0) done <= 1'b1;
          end
        end
        ISSUE: begin
          if (op_ready) done <= 1'b1;
        end
        BLOCK: begin
          if (beat_last) begin
            beat    <= '0;
            word    <= word + 8'd1;
            address <= address + 1'b1;
            if (word_last) done <= 1'b1;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_dispatch.sv
// Directed bench for opcode_dispatch: single issue, block expansion,
// FIFO back-pressure, zero-length NOP, mid-block reset, byte swap.
module tb_opcode_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [15:0] in_data = '0;
  logic [7:0]  in_len = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [2:0]  opcode;
  logic [15:0] data_bus;
  logic        bloc_xfer;
  logic [7:0]  address;
  logic        done;
  logic [2:0]  level;

  int n_vec = 0;
  int n_err = 0;

  opcode_dispatch #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_data   (in_data),
    .in_len    (in_len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .data_bus  (data_bus),
    .bloc_xfer (bloc_xfer),
    .address   (address),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] d, input logic [7:0] l);
    in_valid  = 1'b1;
    in_opcode = op;
    in_data   = d;
    in_len    = l;
  endtask

  logic [2:0]  exp_op [6];
  logic [15:0] exp_dt [6];
  logic [2:0]  got_op [6];
  logic [15:0] got_dt [6];

  initial begin
    int n_iss;
    int n_done;
    int budget;
    logic viol;
    logic accept;
    logic [15:0] swap_exp;

    // ---- Reset state ----
    #2 rst = 1'b1;
    #2;
    check("rst_level",    32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_bloc",     32'(bloc_xfer), 0);
    check("rst_opcode",   32'(opcode), 0);
    check("rst_data",     32'(data_bus), 0);
    check("rst_addr",     32'(address), 0);
    check("rst_done",     32'(done), 0);
    tick();
    rst = 1'b0;
    tick();

    // ---- Single command, op_ready tied high ----
    op_ready = 1'b1;
    drive(3'b100, 16'h1234, 8'd0);
    tick();                       // push edge E
    in_valid = 1'b0;
    check("t1_level_after_push", 32'(level), 1);
    check("t1_no_bypass",        32'(op_valid), 0);
    tick();                       // E+1: pop
    check("t1_op_valid", 32'(op_valid), 1);
    check("t1_opcode",   32'(opcode), 32'h4);
    check("t1_data",     32'(data_bus), 32'h1234);
    check("t1_done_lo",  32'(done), 0);
    tick();                       // E+2: retire
    check("t1_op_valid_drop", 32'(op_valid), 0);
    check("t1_done",          32'(done), 1);
    tick();
    check("t1_done_one_cycle", 32'(done), 0);
    check("t1_addr",           32'(address), 0);

    // ---- Block transfer, len 3 from A0 ----
    drive(3'b000, 16'h00A0, 8'd3);
    tick();
    in_valid = 1'b0;
    tick();                       // pop -> BLOCK
    for (int k = 0; k < 15; k++) begin
      check($sformatf("t2_bloc_%0d", k), 32'(bloc_xfer), 1);
      check($sformatf("t2_data_%0d", k), 32'(data_bus), 32'h00A0 + 32'(k / 5));
      check($sformatf("t2_addr_%0d", k), 32'(address), 32'(k / 5));
      check($sformatf("t2_ov_%0d", k),   32'({op_valid, done}), 0);
      tick();
    end
    check("t2_bloc_end", 32'(bloc_xfer), 0);
    check("t2_done",     32'(done), 1);
    check("t2_addr_end", 32'(address), 3);
    tick();
    check("t2_done_one_cycle", 32'(done), 0);

    // ---- Back-pressure: six commands, op_ready low ----
    op_ready = 1'b0;
    exp_op[0] = 3'b001; exp_dt[0] = 16'h1001;
    exp_op[1] = 3'b010; exp_dt[1] = 16'h1002;
    exp_op[2] = 3'b100; exp_dt[2] = 16'h1003;
    exp_op[3] = 3'b101; exp_dt[3] = 16'h1004;
    exp_op[4] = 3'b110; exp_dt[4] = 16'h1005;
    exp_op[5] = 3'b111; exp_dt[5] = 16'h1006;
    for (int i = 0; i < 5; i++) begin
      drive(exp_op[i], exp_dt[i], 8'd0);
      tick();
    end
    // cmd0 sits in ISSUE, cmds 1..4 fill the FIFO.
    check("t3_level_full", 32'(level), 4);
    check("t3_in_ready",   32'(in_ready), 0);
    check("t3_stall_op",   32'(opcode), 32'(exp_op[0]));
    drive(exp_op[5], exp_dt[5], 8'd0);
    tick();
    tick();
    check("t3_held_level", 32'(level), 4);
    check("t3_held_ready", 32'(in_ready), 0);
    check("t3_held_valid", 32'(op_valid), 1);
    op_ready = 1'b1;
    n_iss  = 0;
    n_done = 0;
    viol   = 1'b0;
    budget = 200;
    while (budget > 0) begin
      if (op_valid && done) viol = 1'b1;
      if (op_valid && bloc_xfer) viol = 1'b1;
      if (op_valid && n_iss < 6) begin
        got_op[n_iss] = opcode;
        got_dt[n_iss] = data_bus;
        n_iss++;
      end
      if (done) n_done++;
      if (n_done == 6) break;
      accept = in_valid && in_ready;
      tick();
      if (accept) in_valid = 1'b0;
      budget--;
    end
    check("t3_issued",  32'(n_iss), 6);
    check("t3_retired", 32'(n_done), 6);
    check("t3_excl",    32'(viol), 0);
    for (int i = 0; i < 6; i++) begin
      if (i < n_iss) begin
        check($sformatf("t3_op_%0d", i), 32'(got_op[i]), 32'(exp_op[i]));
        check($sformatf("t3_dt_%0d", i), 32'(got_dt[i]), 32'(exp_dt[i]));
      end
    end
    check("t3_level_empty", 32'(level), 0);
    tick();

    // ---- Zero-length block is a NOP, next command follows ----
    drive(3'b000, 16'h5555, 8'd0);
    tick();
    drive(3'b110, 16'h7777, 8'd0);
    tick();                       // NOP popped, second cmd pushed
    in_valid = 1'b0;
    check("t4_nop_done",  32'(done), 1);
    check("t4_nop_bloc",  32'(bloc_xfer), 0);
    check("t4_nop_addr",  32'(address), 3);
    check("t4_nop_level", 32'(level), 1);
    tick();
    check("t4_next_valid", 32'(op_valid), 1);
    check("t4_next_op",    32'(opcode), 32'h6);
    check("t4_next_data",  32'(data_bus), 32'h7777);
    check("t4_next_bloc",  32'(bloc_xfer), 0);
    tick();
    check("t4_next_done", 32'(done), 1);
    check("t4_addr_kept", 32'(address), 3);
    tick();

    // ---- Reset during word 2 of a len=4 block ----
    drive(3'b000, 16'h0100, 8'd4);
    tick();
    in_valid = 1'b0;
    tick();                       // BLOCK, k=0
    drive(3'b101, 16'h2222, 8'd0);
    tick();                       // k=1, extra command queued
    in_valid = 1'b0;
    repeat (11) tick();           // k=12
    check("t5_mid_bloc",  32'(bloc_xfer), 1);
    check("t5_mid_data",  32'(data_bus), 32'h0102);
    check("t5_mid_addr",  32'(address), 5);
    check("t5_mid_level", 32'(level), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_bloc",   32'(bloc_xfer), 0);
    check("t5_rst_data",   32'(data_bus), 0);
    check("t5_rst_addr",   32'(address), 0);
    check("t5_rst_level",  32'(level), 0);
    check("t5_rst_opcode", 32'(opcode), 0);
    check("t5_rst_done",   32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t5_no_done",     32'(done), 0);
    check("t5_stays_empty", 32'(level), 0);
    drive(3'b000, 16'h0010, 8'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_new_bloc", 32'(bloc_xfer), 1);
    check("t5_new_addr", 32'(address), 0);
    check("t5_new_data", 32'(data_bus), 32'h0010);
    repeat (5) tick();
    check("t5_new_done",     32'(done), 1);
    check("t5_new_addr_end", 32'(address), 1);
    tick();

    // ---- Opcode 011 data presentation ----
`ifdef DISPATCH_BYTE_SWAP_EN
    swap_exp = 16'hEFBE;
`else
    swap_exp = 16'hBEEF;
`endif
    drive(3'b011, 16'hBEEF, 8'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_valid", 32'(op_valid), 1);
    check("t6_op",    32'(opcode), 32'h3);
    check("t6_data",  32'(data_bus), 32'(swap_exp));
    tick();
    check("t6_done", 32'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
